// File: rtl/pulse_delay_meter_pkg.sv
// Shared types and default sizing for the pulse delay meter.
package pulse_delay_meter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } meter_state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_MAX_CNT = 65535;
  localparam int DEF_MISS_W  = 8;

endpackage

// File: rtl/pulse_delay_meter_rise_edge_det.sv
// Rising-edge detector: one registered history bit, combinational rise output.
module rise_edge_det (
  input  logic alg_clk,
  input  logic alg_rst_n,
  input  logic din,
  output logic rise
);

  logic din_d;

  // History clears to 0 so an input already high after reset reads as a rise.
  always_ff @(posedge alg_clk) begin
    if (!alg_rst_n) din_d <= 1'b0;
    else            din_d <= din;
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/pulse_delay_meter.sv
// Measures alg_clk cycles between a start rise and the matching stop rise.
module pulse_delay_meter
  import pulse_delay_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_CNT = DEF_MAX_CNT,
  parameter int MISS_W  = DEF_MISS_W
) (
  input  logic              alg_clk,
  input  logic              alg_rst_n,
  input  logic              meas_en,
  input  logic              start_pulse,
  input  logic              stop_pulse,
  output logic [CNT_W-1:0]  delay_cnt,
  output logic              delay_valid,
  output logic              timeout,
  output logic              busy,
  output logic [MISS_W-1:0] missed_starts
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CNT);

  logic [1:0] pulse_in, pulse_rise;
  logic       start_rise, stop_rise;

  assign pulse_in = {stop_pulse, start_pulse};

  for (genvar i = 0; i < 2; i++) begin : g_det
    rise_edge_det u_det (
      .alg_clk   (alg_clk),
      .alg_rst_n (alg_rst_n),
      .din       (pulse_in[i]),
      .rise      (pulse_rise[i])
    );
  end

  assign start_rise = pulse_rise[0];
  assign stop_rise  = pulse_rise[1];

  meter_state_t     state, state_nxt;
  logic [CNT_W-1:0] elapsed;
  logic             ld_start, cnt_inc, take_stop, take_zero, fire_to, miss_inc;

  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    cnt_inc   = 1'b0;
    take_stop = 1'b0;
    take_zero = 1'b0;
    fire_to   = 1'b0;
    miss_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (meas_en && start_rise) begin
          if (stop_rise) take_zero = 1'b1;
          else begin
            state_nxt = COUNT;
            ld_start  = 1'b1;
          end
        end
      end
      COUNT: begin
        miss_inc = start_rise;
        // Disable wins over a coincident stop: the measurement is simply dropped.
        if (!meas_en) state_nxt = IDLE;
        else if (stop_rise) begin
          state_nxt = IDLE;
          take_stop = 1'b1;
        end else if (elapsed == LIMIT) begin
          state_nxt = IDLE;
          fire_to   = 1'b1;
        end else cnt_inc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // elapsed holds the edge distance from the start edge to the edge being evaluated.
  always_ff @(posedge alg_clk) begin
    if (!alg_rst_n) begin
      state         <= IDLE;
      elapsed       <= '0;
      delay_cnt     <= '0;
      delay_valid   <= 1'b0;
      timeout       <= 1'b0;
      missed_starts <= '0;
    end else begin
      state       <= state_nxt;
      delay_valid <= take_stop | take_zero;
      timeout     <= fire_to;
      if (ld_start)     elapsed <= CNT_W'(1);
      else if (cnt_inc) elapsed <= elapsed + CNT_W'(1);
      if (take_stop)      delay_cnt <= elapsed;
      else if (take_zero) delay_cnt <= '0;
      if (miss_inc && !(&missed_starts)) missed_starts <= missed_starts + MISS_W'(1);
    end
  end

  assign busy = (state == COUNT);

endmodule

// File: tb/tb_pulse_delay_meter.sv
// Scenario bench for pulse_delay_meter: vector playback with expectations from event timing.
module tb_pulse_delay_meter;

  localparam int CNT_W = 16;
  localparam int MAXC  = 100;
  localparam int MISSW = 8;
  localparam int MAXL  = 400;

  logic             alg_clk = 1'b0;
  logic             alg_rst_n = 1'b0;
  logic             meas_en = 1'b1;
  logic             start_pulse = 1'b0;
  logic             stop_pulse = 1'b0;
  logic [CNT_W-1:0] delay_cnt;
  logic             delay_valid;
  logic             timeout;
  logic             busy;
  logic [MISSW-1:0] missed_starts;

  pulse_delay_meter #(.CNT_W(CNT_W), .MAX_CNT(MAXC), .MISS_W(MISSW)) dut (
    .alg_clk       (alg_clk),
    .alg_rst_n     (alg_rst_n),
    .meas_en       (meas_en),
    .start_pulse   (start_pulse),
    .stop_pulse    (stop_pulse),
    .delay_cnt     (delay_cnt),
    .delay_valid   (delay_valid),
    .timeout       (timeout),
    .busy          (busy),
    .missed_starts (missed_starts)
  );

  always #5 alg_clk = ~alg_clk;

  int total = 0;
  int bad   = 0;
  int exp_missed = 0;
  int exp_last   = 0;

  // Stimulus vectors: entry c is what the c-th rising edge of a run samples.
  logic st_v [MAXL], sp_v [MAXL], en_v [MAXL], rs_v [MAXL];
  // Observations: entry c is the output state just after that edge.
  logic             o_dv [MAXL], o_to [MAXL], o_busy [MAXL];
  logic [CNT_W-1:0] o_cnt [MAXL];
  logic [MISSW-1:0] o_miss [MAXL];

  task automatic clr();
    for (int c = 0; c < MAXL; c++) begin
      st_v[c] = 1'b0; sp_v[c] = 1'b0; en_v[c] = 1'b1; rs_v[c] = 1'b1;
    end
  endtask

  task automatic run(input int len);
    for (int c = 0; c < len; c++) begin
      start_pulse = st_v[c]; stop_pulse = sp_v[c]; meas_en = en_v[c]; alg_rst_n = rs_v[c];
      @(posedge alg_clk); #1;
      o_dv[c] = delay_valid; o_to[c] = timeout; o_busy[c] = busy;
      o_cnt[c] = delay_cnt; o_miss[c] = missed_starts;
    end
  endtask

  function automatic int ones(input int sel, input int len);
    int n = 0;
    for (int c = 0; c < len; c++)
      n += (sel == 0) ? int'(o_dv[c]) : (sel == 1) ? int'(o_to[c]) : int'(o_busy[c]);
    return n;
  endfunction

  task automatic test_reset();
    clr();
    st_v[0] = 1'b1; sp_v[0] = 1'b1; rs_v[0] = 1'b0; rs_v[1] = 1'b0;
    st_v[1] = 1'b1; sp_v[1] = 1'b1;
    run(2);
    total++;
    if ({o_dv[1], o_to[1], o_busy[1], o_cnt[1], o_miss[1]} !== '0) begin
      bad++; $display("FAIL reset_outputs got dv=%b to=%b busy=%b cnt=%0d miss=%0d want all 0",
                      o_dv[1], o_to[1], o_busy[1], o_cnt[1], o_miss[1]);
    end
    // Both inputs high on the first cycle after reset: rises in IDLE together.
    clr();
    st_v[0] = 1'b1; sp_v[0] = 1'b1;
    run(4);
    total++;
    if (o_dv[0] !== 1'b1 || o_cnt[0] !== 0 || o_busy[0] !== 1'b0) begin
      bad++; $display("FAIL post_reset_rise got dv=%b cnt=%0d busy=%b want dv=1 cnt=0 busy=0",
                      o_dv[0], o_cnt[0], o_busy[0]);
    end
    exp_last = 0;
  endtask

  task automatic test_delay_line();
    clr();
    for (int c = 0; c < 5; c++) begin st_v[c] = 1'b1; sp_v[c + 21] = 1'b1; end
    run(32);
    total++;
    if (ones(0, 32) !== 1 || o_dv[21] !== 1'b1) begin
      bad++; $display("FAIL line_valid got count=%0d dv[21]=%b want count=1 dv[21]=1", ones(0, 32), o_dv[21]);
    end
    total++;
    if (o_cnt[21] !== 21) begin
      bad++; $display("FAIL line_delay got %0d want 21", o_cnt[21]);
    end
    total++;
    if (ones(2, 32) !== 21 || o_busy[20] !== 1'b1) begin
      bad++; $display("FAIL line_busy got %0d cycles want 21", ones(2, 32));
    end
    exp_last = 21;
  endtask

  task automatic test_min_delay();
    clr();
    st_v[0] = 1'b1; sp_v[1] = 1'b1;
    run(5);
    total++;
    if (o_dv[1] !== 1'b1 || o_cnt[1] !== 1 || ones(0, 5) !== 1) begin
      bad++; $display("FAIL delay_one got dv=%b cnt=%0d want dv=1 cnt=1", o_dv[1], o_cnt[1]);
    end
    clr();
    st_v[1] = 1'b1; sp_v[1] = 1'b1;
    run(6);
    total++;
    if (o_dv[1] !== 1'b1 || o_cnt[1] !== 0 || ones(2, 6) !== 0) begin
      bad++; $display("FAIL delay_zero got dv=%b cnt=%0d busy_cycles=%0d want dv=1 cnt=0 busy=0",
                      o_dv[1], o_cnt[1], ones(2, 6));
    end
    exp_last = 0;
  endtask

  task automatic test_timeout();
    clr();
    st_v[0] = 1'b1; sp_v[5] = 1'b1;
    run(8);
    exp_last = 5;
    clr();
    st_v[0] = 1'b1;
    run(110);
    total++;
    if (o_to[MAXC] !== 1'b1 || ones(1, 110) !== 1) begin
      bad++; $display("FAIL timeout_pulse got to[%0d]=%b count=%0d want 1/1", MAXC, o_to[MAXC], ones(1, 110));
    end
    total++;
    if (ones(0, 110) !== 0 || o_cnt[109] !== exp_last) begin
      bad++; $display("FAIL timeout_hold got dv_count=%0d cnt=%0d want 0/%0d", ones(0, 110), o_cnt[109], exp_last);
    end
    total++;
    if (ones(2, 110) !== MAXC) begin
      bad++; $display("FAIL timeout_busy got %0d want %0d", ones(2, 110), MAXC);
    end
  endtask

  task automatic test_missed();
    clr();
    st_v[0] = 1'b1; st_v[5] = 1'b1; st_v[9] = 1'b1; sp_v[30] = 1'b1;
    run(36);
    exp_missed += 2; exp_last = 30;
    total++;
    if (o_dv[30] !== 1'b1 || o_cnt[30] !== 30) begin
      bad++; $display("FAIL missed_delay got dv=%b cnt=%0d want 1/30", o_dv[30], o_cnt[30]);
    end
    total++;
    if (o_miss[35] !== exp_missed) begin
      bad++; $display("FAIL missed_two got %0d want %0d", o_miss[35], exp_missed);
    end
    for (int r = 0; r < 8; r++) begin
      clr();
      st_v[0] = 1'b1;
      for (int k = 1; k <= 40; k++) st_v[2 * k] = 1'b1;
      sp_v[90] = 1'b1;
      run(95);
      exp_missed = (exp_missed + 40 > 255) ? 255 : exp_missed + 40;
      exp_last = 90;
      total++;
      if (o_miss[94] !== exp_missed || o_cnt[94] !== 90) begin
        bad++; $display("FAIL missed_sat round=%0d got miss=%0d cnt=%0d want %0d/90", r, o_miss[94], o_cnt[94], exp_missed);
      end
    end
  endtask

  task automatic test_abort();
    clr();
    st_v[0] = 1'b1; en_v[10] = 1'b0; sp_v[10] = 1'b1;
    run(25);
    total++;
    if (ones(0, 25) !== 0 || ones(1, 25) !== 0) begin
      bad++; $display("FAIL abort_strobe got dv=%0d to=%0d want 0/0", ones(0, 25), ones(1, 25));
    end
    total++;
    if (o_busy[9] !== 1'b1 || o_busy[10] !== 1'b0 || o_cnt[24] !== exp_last) begin
      bad++; $display("FAIL abort_idle got busy9=%b busy10=%b cnt=%0d want 1/0/%0d", o_busy[9], o_busy[10], o_cnt[24], exp_last);
    end
    clr();
    st_v[1] = 1'b1; sp_v[8] = 1'b1;
    run(12);
    exp_last = 7;
    total++;
    if (o_dv[8] !== 1'b1 || o_cnt[8] !== 7) begin
      bad++; $display("FAIL reenable_delay got dv=%b cnt=%0d want 1/7", o_dv[8], o_cnt[8]);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    st_v[0] = 1'b1; st_v[3] = 1'b1; rs_v[5] = 1'b0; sp_v[8] = 1'b1;
    run(20);
    exp_missed = 0; exp_last = 0;
    total++;
    if ({o_dv[5], o_to[5], o_busy[5], o_cnt[5], o_miss[5]} !== '0 || o_busy[4] !== 1'b1) begin
      bad++; $display("FAIL reset_mid got dv=%b to=%b busy=%b cnt=%0d miss=%0d want all 0",
                      o_dv[5], o_to[5], o_busy[5], o_cnt[5], o_miss[5]);
    end
    total++;
    if (ones(0, 20) !== 0 || o_busy[9] !== 1'b0 || o_cnt[19] !== 0) begin
      bad++; $display("FAIL reset_mid_stop got dv_count=%0d busy=%b cnt=%0d want 0/0/0", ones(0, 20), o_busy[9], o_cnt[19]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int g, len, endc, n;
      g    = int'($urandom_range(1, 130));
      endc = (g < MAXC) ? g : MAXC;
      len  = ((g > MAXC) ? g : MAXC) + 6;
      n    = 0;
      clr();
      st_v[0] = 1'b1; sp_v[g] = 1'b1;
      for (int c = 2; c <= endc; c++)
        if ($urandom_range(0, 3) == 0 && !st_v[c - 1]) begin st_v[c] = 1'b1; n++; end
      run(len);
      exp_missed = (exp_missed + n > 255) ? 255 : exp_missed + n;
      if (g <= MAXC) exp_last = g;
      total++;
      if (g <= MAXC && (o_dv[g] !== 1'b1 || ones(0, len) !== 1 || ones(1, len) !== 0)) begin
        bad++; $display("FAIL rand_valid it=%0d gap=%0d got dv=%b count=%0d to=%0d", it, g, o_dv[g], ones(0, len), ones(1, len));
      end else if (g > MAXC && (o_to[MAXC] !== 1'b1 || ones(0, len) !== 0 || ones(1, len) !== 1)) begin
        bad++; $display("FAIL rand_timeout it=%0d gap=%0d got to=%b dv_count=%0d", it, g, o_to[MAXC], ones(0, len));
      end
      total++;
      if (o_cnt[len - 1] !== exp_last || o_miss[len - 1] !== exp_missed || ones(2, len) !== endc) begin
        bad++; $display("FAIL rand_state it=%0d got cnt=%0d miss=%0d busy=%0d want %0d/%0d/%0d",
                        it, o_cnt[len - 1], o_miss[len - 1], ones(2, len), exp_last, exp_missed, endc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_delay_line();
    test_min_delay();
    test_timeout();
    test_missed();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
